// File: rtl/apb3_master_bridge_if.sv
// Bundle of the command/response port and the APB3 bus driven by apb3_master_bridge.
// The master modport is the bridge's view; the slave modport is the requester and APB slave side.
interface apb3_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb3_master_bridge.sv
// APB3 requester: single read/write commands in, SETUP/ACCESS sequence out, one-cycle response strobe.
// Optional ACCESS timeout abort is built in when APB_MS_TIMEOUT_EN is defined.
module apb3_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb3_master_bridge_if.master bus
);
  // state  | meaning
  // IDLE   | no transfer; cmd_ready high once out of reset
  // SETUP  | PSELx=1, PENABLE=0 for exactly one cycle
  // ACCESS | PSELx=1, PENABLE=1 until PREADY (or timeout abort)
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_live;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;

  // r_live keeps cmd_ready low until the first edge after reset release
  assign w_cmd_ready = r_live && ((r_state == S_IDLE) || ((r_state == S_ACCESS) && bus.PREADY));
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_done      = (r_state == S_ACCESS) && bus.PREADY;

`ifdef APB_MS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_rsp_timeout;

  // PREADY on the terminal edge wins, so abort only with PREADY low
  assign w_abort = (r_state == S_ACCESS) && !bus.PREADY && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state != S_ACCESS) r_wait_cnt <= '0;
      else if (!bus.PREADY)    r_wait_cnt <= r_wait_cnt + 1'b1;
      r_rsp_timeout <= w_abort;
    end
  end

  assign bus.rsp_timeout = r_rsp_timeout;
`else
  assign w_abort         = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_done)       w_state_nxt = w_accept ? S_SETUP : S_IDLE;
        else if (w_abort) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_wdata;
      end
      // r_pwrite still describes the completing transfer on a back-to-back edge
      r_rsp_valid <= w_done || w_abort;
      r_rsp_err   <= w_done ? bus.PSLVERR : w_abort;
      r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.PSELx     = (r_state != S_IDLE);
  assign bus.PENABLE   = (r_state == S_ACCESS);
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule
